// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit for the EX stage.
// Multiply: product formed on the start edge and held for MUL_STAGES stall cycles.
// Divide: restoring, one quotient bit per cycle (first bit on the start edge).
module ex_muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ValidE,
  input  logic            FlushE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic            StallE,
  output logic            MulDivValid,
  output logic [XLEN-1:0] MulDivResult
);

  localparam int unsigned CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PW      = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  // One restoring-division step; returns {remainder, quotient/dividend shift reg}.
  function automatic logic [PW-1:0] div_step(input logic [XLEN-1:0] rem,
                                             input logic [XLEN-1:0] quo,
                                             input logic [XLEN-1:0] dvs);
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] diff;
    logic            ge;
    trial    = {rem, quo[XLEN-1]};
    ge       = (trial >= {1'b0, dvs});
    diff     = trial[XLEN-1:0] - dvs;
    div_step = {(ge ? diff : trial[XLEN-1:0]), quo[XLEN-2:0], ge};
  endfunction

  // Select the low or high product half by operation.
  function automatic logic [XLEN-1:0] mul_pick(input logic [PW-1:0] p, input logic [2:0] f3);
    mul_pick = (f3[1:0] == 2'b00) ? p[XLEN-1:0] : p[PW-1:XLEN];
  endfunction

  // Apply signs to the unsigned quotient/remainder and pick the requested one.
  function automatic logic [XLEN-1:0] div_fix(input logic [PW-1:0] rq, input logic [2:0] f3,
                                              input logic nq, input logic nr);
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    q = rq[XLEN-1:0];
    r = rq[PW-1:XLEN];
    if (f3[1]) div_fix = nr ? (~r + XLEN'(1)) : r;
    else       div_fix = nq ? (~q + XLEN'(1)) : q;
  endfunction

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            negq_q, negq_d, negr_q, negr_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            start;
  logic            div_signed, a_sgn_div, b_sgn_div, a_sgn_mul, b_sgn_mul;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [PW-1:0]   a_ext, b_ext, prod_full;
  logic            b_zero, ovf;
  logic [PW-1:0]   step0, step_n;

  // Operand conditioning for the start cycle.
  always_comb begin
    div_signed = ~funct3E[0];
    a_sgn_div  = div_signed & SrcAE[XLEN-1];
    b_sgn_div  = div_signed & SrcBE[XLEN-1];
    a_abs      = a_sgn_div ? (~SrcAE + XLEN'(1)) : SrcAE;
    b_abs      = b_sgn_div ? (~SrcBE + XLEN'(1)) : SrcBE;
    a_sgn_mul  = ((funct3E[1:0] == 2'b01) || (funct3E[1:0] == 2'b10)) & SrcAE[XLEN-1];
    b_sgn_mul  = (funct3E[1:0] == 2'b01) & SrcBE[XLEN-1];
    a_ext      = {{XLEN{a_sgn_mul}}, SrcAE};
    b_ext      = {{XLEN{b_sgn_mul}}, SrcBE};
    prod_full  = a_ext * b_ext;
    b_zero     = (SrcBE == '0);
    ovf        = div_signed & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (&SrcBE);
    step0      = div_step('0, a_abs, b_abs);
    step_n     = div_step(rem_q, quo_q, dvs_q);
  end

  assign start = ValidE & ~FlushE;

  // Next-state, datapath updates and result capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    prod_d   = prod_q;
    result_d = '0;
    if (FlushE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_d = funct3E;
            if (!funct3E[2]) begin
              prod_d = prod_full;
              if (MUL_STAGES == 1) begin
                state_d  = DONE;
                result_d = mul_pick(prod_full, funct3E);
              end else begin
                state_d = MUL;
                cnt_d   = CNT_W'(MUL_STAGES - 1);
              end
            end else if (b_zero) begin
              state_d  = DONE;
              result_d = funct3E[1] ? SrcAE : '1;
            end else if (ovf) begin
              state_d  = DONE;
              result_d = funct3E[1] ? '0 : SrcAE;
            end else begin
              state_d = DIV;
              cnt_d   = CNT_W'(XLEN - 1);
              negq_d  = a_sgn_div ^ b_sgn_div;
              negr_d  = a_sgn_div;
              dvs_d   = b_abs;
              rem_d   = step0[PW-1:XLEN];
              quo_d   = step0[XLEN-1:0];
            end
          end
        end
        MUL: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = DONE;
            result_d = mul_pick(prod_q, op_q);
          end
        end
        DIV: begin
          cnt_d = cnt_q - CNT_W'(1);
          rem_d = step_n[PW-1:XLEN];
          quo_d = step_n[XLEN-1:0];
          if (cnt_q == CNT_W'(1)) begin
            state_d  = DONE;
            result_d = div_fix(step_n, op_q, negq_q, negr_q);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

  // Stall is combinational so the start cycle itself is held; forced low in reset.
  assign StallE       = rst_n & ValidE & ~FlushE & (state_q != DONE);
  assign MulDivValid  = (state_q == DONE);
  assign MulDivResult = result_q;

endmodule
